// File: rtl/draw_sprite.sv
// Sprite overlay stage: addresses a 64x64 synchronous texture ROM and composites its texel over the background.
// Optional colour-key transparency is enabled by defining DRAW_SPRITE_KEY_EN.
module draw_sprite #(
  parameter int          SPRITE_W  = 64,
  parameter int          SPRITE_H  = 64,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

  localparam logic [12:0] W13 = 13'(SPRITE_W);
  localparam logic [12:0] H13 = 13'(SPRITE_H);

  logic        vblnk_prev_q;
  logic [11:0] x_act_q, y_act_q;
  logic [11:0] rom_addr_q, rom_addr_d;
  timing_t     s1_q, s2_q, out_q, s1_d;
  logic        in_rect1_q, in_rect2_q, in_rect_d;
  logic [11:0] rgb_out_q, rgb_out_d;
  logic [12:0] h13, v13, x13, y13;
  logic [5:0]  dx, dy;
  logic        show_tex;

  // 13-bit compares keep x_act + SPRITE_W from wrapping near 4095
  always_comb begin
    h13 = {2'b00, hcount_in};
    v13 = {2'b00, vcount_in};
    x13 = {1'b0, x_act_q};
    y13 = {1'b0, y_act_q};
    dx  = hcount_in[5:0] - x_act_q[5:0];
    dy  = vcount_in[5:0] - y_act_q[5:0];
    in_rect_d = (h13 >= x13) && (h13 < x13 + W13) &&
                (v13 >= y13) && (v13 < y13 + H13) &&
                !(hblnk_in || vblnk_in);
    rom_addr_d = in_rect_d ? {dy, dx} : rom_addr_q;
    s1_d = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
             vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in};
  end

`ifdef DRAW_SPRITE_KEY_EN
  assign show_tex = in_rect2_q && (rom_rgb != KEY_COLOR);
`else
  logic key_unused;
  assign key_unused = ^KEY_COLOR;
  assign show_tex   = in_rect2_q;
`endif

  always_comb begin
    rgb_out_d = 12'h000;
    if (!(s2_q.hblnk || s2_q.vblnk))
      rgb_out_d = show_tex ? rom_rgb : s2_q.rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      x_act_q      <= '0;
      y_act_q      <= '0;
      rom_addr_q   <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_q        <= '0;
      in_rect1_q   <= 1'b0;
      in_rect2_q   <= 1'b0;
      rgb_out_q    <= '0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      // position only moves at the start of vertical blank, so a frame never tears
      if (vblnk_in && !vblnk_prev_q) begin
        x_act_q <= xpos;
        y_act_q <= ypos;
      end
      rom_addr_q <= rom_addr_d;
      s1_q       <= s1_d;
      in_rect1_q <= in_rect_d;
      s2_q       <= s1_q;
      in_rect2_q <= in_rect1_q;
      out_q      <= s2_q;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign vcount_out = out_q.vcount;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite with a behavioural 1-cycle ROM returning addr ^ 12'h5A5.
module tb_draw_sprite;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [11:0] rom_addr, rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  int tests = 0;
  int fails = 0;

`ifdef DRAW_SPRITE_KEY_EN
  localparam logic [11:0] KEY_EXP = 12'hABC;
`else
  localparam logic [11:0] KEY_EXP = 12'hF0F;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) rom_rgb <= rom_addr ^ 12'h5A5;

  draw_sprite dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] a;
    logic [11:0] o;
  } vec_t;

  vec_t tbl[23];
  logic [25:0] hist[40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic [11:0] rgb);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic new_frame(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk); drive(11'd0, 11'd0, 1'b1, 1'b0, 12'h000); xpos = x; ypos = y;
    @(negedge clk); vblnk_in = 1'b1;
    @(negedge clk); vblnk_in = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb);
      @(negedge clk);
      check($sformatf("addr[%0d]", i), rom_addr, tbl[i].a);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rgb[%0d]", i), rgb_out, tbl[i].o);
      check($sformatf("hcnt[%0d]", i), {vcount_out, hcount_out}, {tbl[i].v, tbl[i].h});
    end
  endtask

  initial begin
    tbl[0]  = '{11'd100,  11'd50,  1'b0, 1'b0, 12'h111, 12'h000, 12'h5A5};
    tbl[1]  = '{11'd163,  11'd113, 1'b0, 1'b0, 12'h222, 12'hFFF, 12'hA5A};
    tbl[2]  = '{11'd164,  11'd113, 1'b0, 1'b0, 12'h333, 12'hFFF, 12'h333};
    tbl[3]  = '{11'd99,   11'd50,  1'b0, 1'b0, 12'h444, 12'hFFF, 12'h444};
    tbl[4]  = '{11'd130,  11'd80,  1'b0, 1'b0, 12'h555, 12'h79E, 12'h23B};
    tbl[5]  = '{11'd100,  11'd49,  1'b0, 1'b0, 12'h666, 12'h79E, 12'h666};
    tbl[6]  = '{11'd100,  11'd114, 1'b0, 1'b0, 12'h777, 12'h79E, 12'h777};
    tbl[7]  = '{11'd130,  11'd80,  1'b1, 1'b0, 12'h888, 12'h79E, 12'h000};
    tbl[8]  = '{11'd121,  11'd71,  1'b0, 1'b0, 12'h999, 12'h555, 12'h0F0};
    tbl[9]  = '{11'd142,  11'd92,  1'b0, 1'b0, 12'hABC, 12'hAAA, KEY_EXP};
    tbl[10] = '{11'd163,  11'd50,  1'b0, 1'b0, 12'hDEF, 12'h03F, 12'h59A};
    tbl[11] = '{11'd100,  11'd113, 1'b0, 1'b0, 12'h123, 12'hFC0, 12'hA65};
    tbl[12] = '{11'd130,  11'd80,  1'b0, 1'b1, 12'h456, 12'hFC0, 12'h000};
    tbl[13] = '{11'd100,  11'd50,  1'b0, 1'b0, 12'h321, 12'h000, 12'h5A5};
    tbl[14] = '{11'd300,  11'd50,  1'b0, 1'b0, 12'h654, 12'h000, 12'h654};
    tbl[15] = '{11'd300,  11'd50,  1'b0, 1'b0, 12'h987, 12'h000, 12'h5A5};
    tbl[16] = '{11'd100,  11'd50,  1'b0, 1'b0, 12'h246, 12'h000, 12'h246};
    tbl[17] = '{11'd363,  11'd113, 1'b0, 1'b0, 12'h135, 12'hFFF, 12'hA5A};
    tbl[18] = '{11'd1000, 11'd50,  1'b0, 1'b0, 12'h0AA, 12'h000, 12'h5A5};
    tbl[19] = '{11'd1023, 11'd50,  1'b0, 1'b0, 12'h0BB, 12'h017, 12'h5B2};
    tbl[20] = '{11'd0,    11'd50,  1'b0, 1'b0, 12'h0CC, 12'h017, 12'h0CC};
    tbl[21] = '{11'd39,   11'd50,  1'b0, 1'b0, 12'h0DD, 12'h017, 12'h0DD};
    tbl[22] = '{11'd999,  11'd50,  1'b0, 1'b0, 12'h0EE, 12'h017, 12'h0EE};

    // reset with busy inputs, then release into blanking
    rst = 1'b1; xpos = 12'd0; ypos = 12'd0;
    drive(11'd77, 11'd33, 1'b0, 1'b0, 12'hFFF);
    hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_addr", rom_addr, 12'h000);
    check("rst_timing", {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}, 26'd0);
    rst = 1'b0;
    drive(11'd5, 11'd5, 1'b1, 1'b1, 12'hFFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("blank_after_rst", rgb_out, 12'h000);
    end

    new_frame(12'd100, 12'd50);
    run_range(0, 12);
    xpos = 12'd300;
    run_range(13, 14);
    new_frame(12'd300, 12'd50);
    run_range(15, 17);
    new_frame(12'd1000, 12'd50);
    run_range(18, 22);

    // every timing output is its input delayed exactly three cycles
    xpos = 12'd0; ypos = 12'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 3)
        check($sformatf("align[%0d]", i),
              {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, hist[i-3]);
      hcount_in = 11'($urandom_range(0, 2047));
      vcount_in = 11'($urandom_range(0, 2047));
      hsync_in  = 1'($urandom_range(0, 1));
      hblnk_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      vblnk_in  = 1'($urandom_range(0, 1));
      rgb_in    = 12'($urandom_range(0, 4095));
      hist[i] = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
    end

    // mid-frame reset also clears the latched position to 0,0
    @(negedge clk);
    drive(11'd10, 11'd5, 1'b0, 1'b0, 12'hABC);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rgb", rgb_out, 12'h000);
    check("midrst_addr", rom_addr, 12'h000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rgb1", rgb_out, 12'h000);
    check("post_rst_addr", rom_addr, 12'h14A);
    @(negedge clk);
    check("post_rst_rgb2", rgb_out, 12'h000);
    @(negedge clk);
    check("post_rst_rgb3", rgb_out, 12'h4EF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
